// File: rtl/inst_rom_resp.sv
// inst_rom_resp: instruction memory responder with wait states, ready/error handshake and load port
// Ports: clk/rst; ce_i, addr_i fetch request; inst_o, ready_o, err_o response;
//   busy_o request-not-accepted flag; load_en_i, load_addr_i, load_data_i array write port
module inst_rom_resp #(
  parameter int DATA_W = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ERR_INST = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [DATA_W-1:0]     inst_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic                  busy_o,
  input  logic                  load_en_i,
  input  logic [DEPTH_LOG2-1:0] load_addr_i,
  input  logic [DATA_W-1:0]     load_data_i
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d, req_idx;
  logic err_q, err_d, req_err, accept, direct;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  assign req_idx = addr_i[DEPTH_LOG2+1:2];
  assign req_err = |addr_i[1:0] || |addr_i[31:DEPTH_LOG2+2];
  assign accept = ce_i && !load_en_i && state_q != WAIT;
  // errors and zero-wait requests skip WAIT and answer on the next cycle
  assign direct = WAIT_STATES == 0 || req_err;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    err_d = err_q;
    inst_d = inst_q;
    if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = !ce_i ? IDLE : cnt_q == 4'd1 ? RESP : WAIT;
      if (ce_i && cnt_q == 4'd1) inst_d = mem[idx_q];
    end else if (accept) begin
      cnt_d = 4'(WAIT_STATES);
      idx_d = req_idx;
      err_d = req_err;
      state_d = direct ? RESP : WAIT;
      if (direct) inst_d = req_err ? ERR_INST : mem[req_idx];
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      inst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      err_q <= err_d;
      inst_q <= inst_d;
    end
  end
  // capture above reads the pre-write word when a load hits the same index
  always_ff @(posedge clk) if (load_en_i) mem[load_addr_i] <= load_data_i;
  assign inst_o = inst_q;
  assign ready_o = state_q == RESP;
  assign err_o = ready_o && err_q;
  assign busy_o = state_q == WAIT || load_en_i;
endmodule

// File: tb/tb_inst_rom_resp.sv
// tb_inst_rom_resp: scoreboard bench over three responders with 0, 1 and 3 wait states
module tb_inst_rom_resp;
  logic clk = 0, rst = 1;
  logic ce [3], le [3], rdy [3], er [3], bsy [3];
  logic [31:0] addr [3], inst [3], ld [3];
  logic [9:0] la [3];
  logic [31:0] words [4] = '{32'h2401_0001, 32'h2402_0002, 32'h2403_0003, 32'h2404_0004};
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int dut; logic [31:0] inst; logic err; int cyc;} exp_t;
  exp_t sb [$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    inst_rom_resp #(.WAIT_STATES(g == 0 ? 0 : g == 1 ? 1 : 3)) dut (
      .clk(clk), .rst(rst), .ce_i(ce[g]), .addr_i(addr[g]), .inst_o(inst[g]),
      .ready_o(rdy[g]), .err_o(er[g]), .busy_o(bsy[g]), .load_en_i(le[g]),
      .load_addr_i(la[g]), .load_data_i(ld[g]));
  end
  always @(negedge clk) if (!rst) for (int d = 0; d < 3; d++) if (rdy[d]) begin
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_ready: dut%0d cyc %0d inst %h err %b, none expected", d, cyc, inst[d], er[d]);
    end else begin
      e = sb.pop_front();
      if (e.dut != d || inst[d] !== e.inst || er[d] !== e.err || cyc != e.cyc) begin
        fails++;
        $display("FAIL resp: got dut%0d inst %h err %b cyc %0d, want dut%0d inst %h err %b cyc %0d",
                 d, inst[d], er[d], cyc, e.dut, e.inst, e.err, e.cyc);
      end
    end
  end
  function automatic int ws(int d);
    return d == 0 ? 0 : d == 1 ? 1 : 3;
  endfunction
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  task automatic fetch(int d, logic [31:0] a, logic [31:0] w, logic bad);
    ce[d] = 1;
    addr[d] = a;
    sb.push_back('{d, w, bad, cyc + 1 + (bad ? 0 : ws(d))});
    step();
    if (!bad && ws(d) > 0) chk("busy_wait", 32'(bsy[d]), 32'd1);
    step(bad ? 0 : ws(d));
    ce[d] = 0;
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      ce[d] = 0; le[d] = 0; addr[d] = 0; la[d] = 0; ld[d] = 0;
    end
    step(3);
    for (int d = 0; d < 3; d++) begin
      chk("rst_inst", inst[d], 32'h0);
      chk("rst_ready", 32'(rdy[d]), 32'd0);
      chk("rst_err", 32'(er[d]), 32'd0);
    end
    rst = 0;
    for (int w = 0; w < 5; w++) begin
      for (int d = 0; d < 3; d++) begin
        le[d] = 1;
        la[d] = w < 4 ? 10'(w) : 10'h3ff;
        ld[d] = w < 4 ? words[w] : 32'h1234_5678;
      end
      #1 if (w == 0) chk("busy_load", 32'(bsy[0]), 32'd1);
      step();
    end
    for (int d = 0; d < 3; d++) le[d] = 0;
    step();
    fetch(1, 32'h0, words[0], 0);
    step(2);
    for (int i = 0; i < 4; i++) begin
      fetch(0, 32'(i * 4), words[i], 0);
      chk("busy_w0", 32'(bsy[0]), 32'd0);
    end
    fetch(0, 32'h8, words[2], 0);
    fetch(0, 32'h8, words[2], 0);
    fetch(0, 32'hffc, 32'h1234_5678, 0);
    fetch(0, 32'h6, 32'h0, 1);
    step();
    fetch(2, 32'h6, 32'h0, 1);
    fetch(2, 32'h1000, 32'h0, 1);
    fetch(2, 32'h8000_0000, 32'h0, 1);
    step();
    le[0] = 1; la[0] = 10'd5; ld[0] = 32'h55; ce[0] = 1; addr[0] = 32'h4;
    #1 chk("busy_load_block", 32'(bsy[0]), 32'd1);
    step();
    le[0] = 0;
    fetch(0, 32'h4, words[1], 0);
    step();
    fetch(2, 32'hc, words[3], 0);
    ce[2] = 1; addr[2] = 32'h8;
    step(2);
    ce[2] = 0;
    step();
    chk("abort_inst_hold", inst[2], words[3]);
    chk("abort_idle", 32'(bsy[2]), 32'd0);
    step(4);
    ce[1] = 1; addr[1] = 32'h4;
    sb.push_back('{1, words[1], 1'b0, cyc + 2});
    step();
    le[1] = 1; la[1] = 10'd1; ld[1] = 32'hdead_beef;
    step();
    le[1] = 0; ce[1] = 0;
    step();
    fetch(1, 32'h4, 32'hdead_beef, 0);
    step(2);
    ce[2] = 1; addr[2] = 32'h8;
    step(2);
    rst = 1;
    step();
    chk("rst_wait_inst", inst[2], 32'h0);
    chk("rst_wait_ready", 32'(rdy[2]), 32'd0);
    chk("rst_wait_err", 32'(er[2]), 32'd0);
    rst = 0; ce[2] = 0;
    step();
    fetch(2, 32'h8, words[2], 0);
    step(6);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
Instruction-memory responder on the far side of the core's fetch port. It accepts a fetch request (chip enable plus byte address from the PC stage) and returns the 32-bit instruction word after a configurable number of wait states, with a ready/error handshake. It also provides a write-only load port so the bench or a boot loader can fill the array before and during execution.

Parameters:
DATA_W, 32, instruction word width
DEPTH_LOG2, 10, log2 of the number of words (default 1024 words, 4 KiB)
WAIT_STATES, 1, extra cycles inserted before the response; legal range 0..15
ERR_INST, 32'h0000_0000, value driven on inst_o for an error response (a MIPS NOP)

Ports:
clk  in  1  system clock, all state updates on its rising edge
rst  in  1  synchronous, active-high reset
ce_i  in  1  fetch request enable from the core
addr_i  in  32  fetch byte address (the PC)
inst_o  out  DATA_W  returned instruction word (registered)
ready_o  out  1  one-cycle pulse: inst_o is valid this cycle
err_o  out  1  qualifies ready_o: the address was misaligned or out of range
busy_o  out  1  a request presented this cycle will not be accepted
load_en_i  in  1  write strobe for the load port
load_addr_i  in  DEPTH_LOG2  word index for the load write
load_data_i  in  DATA_W  word to write

Behaviour:
- Storage and decode
  - Storage is DEPTH words.
  - Word index is addr_i[DEPTH_LOG2+1:2].
  - Misaligned: addr_i[1:0] != 0.
  - Out of range: addr_i[31:DEPTH_LOG2+2] != 0.
  - The array is not reset.
- Reset
  - State goes to IDLE; inst_o=0, ready_o=0, err_o=0, wait counter=0.
  - Reset in any state abandons the in-flight request; no ready pulse is produced.
- FSM states: IDLE, WAIT, RESP.
- Acceptance condition: ce_i=1 and load_en_i=0, evaluated in IDLE or RESP.
- On acceptance
  - Latch the word index and the error flag.
  - Load counter = WAIT_STATES.
  - Go to WAIT if the counter is nonzero and there is no error; otherwise go directly to RESP.
- WAIT
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture the data and move to RESP.
  - If ce_i=0 in any WAIT cycle, abort to IDLE; no ready pulse, inst_o unchanged.
- RESP (lasts exactly one cycle)
  - ready_o=1.
  - inst_o = mem[latched index], or ERR_INST with err_o=1 if the request was in error.
  - If a new request is accepted in the same cycle, go back to WAIT/RESP (back-to-back operation). Otherwise go to IDLE.
- Latency
  - A request accepted at edge T produces ready_o during cycle T+1+WAIT_STATES.
  - Error responses always take 1 cycle.
  - With WAIT_STATES=0, throughput is one word per cycle.
- Holding of outputs
  - inst_o holds its value between responses.
  - ready_o and err_o are 0 outside RESP.
- busy_o = (state==WAIT) | load_en_i (combinational).
- Load port
  - mem[load_addr_i] <= load_data_i on any edge with load_en_i=1, in any state.
  - Read-before-write: if the load hits the word being captured on the same edge, the old word is returned.
  - In IDLE/RESP, load_en_i blocks acceptance for that cycle.
- ce_i=1 held constant with an unchanged addr_i re-fetches the same word each time; there is no caching.

Test Plan:
- Reset, then load words 0..3 = 0x24010001, 0x24020002, 0x24030003, 0x24040004. Set WAIT_STATES=1, ce_i=1, addr_i=0x0. -> Response 2 cycles after acceptance: ready_o=1, inst_o=0x24010001, err_o=0.
- Set WAIT_STATES=0 and step ce_i=1 with addr_i through 0x0, 0x4, 0x8, 0xC on consecutive cycles. -> ready_o high for 4 consecutive cycles, inst_o matches each word in order, busy_o stays 0.
- Fetch addr_i=0x6 (misaligned), then addr_i=0x0000_1000 with DEPTH_LOG2=10 (out of range). -> Each gives a one-cycle response with ready_o=1, err_o=1, inst_o=0x00000000.
- Set WAIT_STATES=3, accept a request, then drop ce_i in the 2nd WAIT cycle. -> No ready_o pulse, FSM back in IDLE, inst_o keeps its previous value.
- Assert load_en_i to word 1 (data 0xDEADBEEF) on the same edge the fetch of 0x4 captures its data. -> The response returns 0x24020002; a refetch of 0x4 returns 0xDEADBEEF.
- Assert rst while in WAIT (WAIT_STATES=3). -> Next cycle ready_o=0, err_o=0, inst_o=0; a new fetch of 0x8 completes normally with 0x24030003.
